// File: rtl/response_router.sv
// Returns AXI read-data bursts to the master port that issued them, using the
// request-path ID table to find the owner and draining bursts nobody claims.
module response_router #(
   parameter int NUMBER_OF_PORTS = 2,
   parameter int ID_WIDTH        = 16,
   parameter int DATA_WIDTH      = 128,
   parameter int PORT_WIDTH      = (NUMBER_OF_PORTS > 1) ? $clog2(NUMBER_OF_PORTS) : 1
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [ID_WIDTH-1:0]        s_rid,
   input  logic [DATA_WIDTH-1:0]      s_rdata,
   input  logic [1:0]                 s_rresp,
   input  logic                       s_rlast,
   input  logic                       s_rvalid,
   output logic                       s_rready,
   output logic [ID_WIDTH-1:0]        m_rid,
   output logic [DATA_WIDTH-1:0]      m_rdata,
   output logic [1:0]                 m_rresp,
   output logic                       m_rlast,
   output logic [NUMBER_OF_PORTS-1:0] m_rvalid,
   input  logic [NUMBER_OF_PORTS-1:0] m_rready,
   output logic [ID_WIDTH-1:0]        tbl_id,
   output logic                       tbl_lookup,
   output logic                       tbl_invalidate,
   input  logic [PORT_WIDTH-1:0]      tbl_answer,
   input  logic                       tbl_hit,
   output logic                       miss,
   output logic [15:0]                miss_count
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT,
      FORWARD,
      DROP,
      RELEASE
   } state_t;

   localparam logic [PORT_WIDTH:0] PORT_LIMIT = (PORT_WIDTH + 1)'(NUMBER_OF_PORTS);

   state_t                state;
   logic [ID_WIDTH-1:0]   cur_id;
   logic [PORT_WIDTH-1:0] cur_port;
   logic                  answer_ok;
   logic                  beat_xfer;

   // An answer naming a port we do not have is treated exactly like a miss.
   assign answer_ok = tbl_hit && ({1'b0, tbl_answer} < PORT_LIMIT);
   assign beat_xfer = s_rvalid && s_rready;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         cur_id     <= '0;
         cur_port   <= '0;
         miss_count <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (s_rvalid) begin
                  cur_id <= s_rid;
                  state  <= WAIT;
               end
            end
            WAIT: begin
               if (answer_ok) begin
                  cur_port <= tbl_answer;
                  state    <= FORWARD;
               end else begin
                  if (miss_count != 16'hFFFF) begin
                     miss_count <= miss_count + 16'd1;
                  end
                  state <= DROP;
               end
            end
            FORWARD: begin
               if (beat_xfer && s_rlast) begin
                  state <= RELEASE;
               end
            end
            DROP: begin
               if (beat_xfer && s_rlast) begin
                  state <= IDLE;
               end
            end
            RELEASE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Handshake is steered combinationally so port back-pressure reaches memory in the same cycle.
   always_comb begin
      s_rready = 1'b0;
      m_rvalid = '0;
      case (state)
         FORWARD: begin
            s_rready           = m_rready[cur_port];
            m_rvalid[cur_port] = s_rvalid;
         end
         DROP: begin
            s_rready = 1'b1;
         end
         default: begin
         end
      endcase
   end

   assign tbl_id         = (state == IDLE) ? s_rid : cur_id;
   assign tbl_lookup     = (state == IDLE) && s_rvalid;
   assign tbl_invalidate = (state == RELEASE);
   assign miss           = (state == WAIT) && !answer_ok;

   assign m_rid   = s_rid;
   assign m_rdata = s_rdata;
   assign m_rresp = s_rresp;
   assign m_rlast = s_rlast;

endmodule

// File: tb/tb_response_router.sv
// Directed bench for response_router: a small ID-table model answers lookups and
// a scoreboard of expected beats is checked against every port-side transfer.
module tb_response_router;

   typedef struct {
      int           port;
      logic [15:0]  rid;
      logic [127:0] data;
      logic [1:0]   resp;
      logic         last;
   } beat_t;

   logic         clock;
   logic         reset;
   logic [15:0]  s_rid;
   logic [127:0] s_rdata;
   logic [1:0]   s_rresp;
   logic         s_rlast;
   logic         s_rvalid;
   logic         s_rready;
   logic [15:0]  m_rid;
   logic [127:0] m_rdata;
   logic [1:0]   m_rresp;
   logic         m_rlast;
   logic [1:0]   m_rvalid;
   logic [1:0]   m_rready;
   logic [15:0]  tbl_id;
   logic         tbl_lookup;
   logic         tbl_invalidate;
   logic [0:0]   tbl_answer;
   logic         tbl_hit;
   logic         miss;
   logic [15:0]  miss_count;

   int    checks;
   int    errors;
   int    inv_count;
   int    miss_pulses;
   beat_t sb[$];
   beat_t mon_beat;

   response_router dut (
      .clock          (clock),
      .reset          (reset),
      .s_rid          (s_rid),
      .s_rdata        (s_rdata),
      .s_rresp        (s_rresp),
      .s_rlast        (s_rlast),
      .s_rvalid       (s_rvalid),
      .s_rready       (s_rready),
      .m_rid          (m_rid),
      .m_rdata        (m_rdata),
      .m_rresp        (m_rresp),
      .m_rlast        (m_rlast),
      .m_rvalid       (m_rvalid),
      .m_rready       (m_rready),
      .tbl_id         (tbl_id),
      .tbl_lookup     (tbl_lookup),
      .tbl_invalidate (tbl_invalidate),
      .tbl_answer     (tbl_answer),
      .tbl_hit        (tbl_hit),
      .miss           (miss),
      .miss_count     (miss_count)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // ID table model: fixed contents, answer one cycle after the lookup strobe.
   always @(posedge clock or negedge reset) begin
      if (!reset) begin
         tbl_hit    <= 1'b0;
         tbl_answer <= 1'b0;
      end else if (tbl_lookup) begin
         case (tbl_id)
            16'h01ad: begin tbl_hit <= 1'b1; tbl_answer <= 1'b1; end
            16'h018d: begin tbl_hit <= 1'b1; tbl_answer <= 1'b0; end
            16'h01ed: begin tbl_hit <= 1'b1; tbl_answer <= 1'b0; end
            default:  begin tbl_hit <= 1'b0; tbl_answer <= 1'b0; end
         endcase
      end else begin
         tbl_hit <= 1'b0;
      end
   end

   task automatic check_output(input string tag, input logic [127:0] observed,
                               input logic [127:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic logic [127:0] beat_data(input logic [15:0] id, input int b);
      return {8{id ^ 16'(b * 16'h1111)}};
   endfunction

   task automatic tick;
      @(posedge clock);
      #2;
   endtask

   // Present one beat on the memory side; owned beats go onto the scoreboard.
   task automatic drive_beat(input logic [15:0] id, input int b, input int nbeats,
                             input bit hit, input int port);
      beat_t e;
      s_rid    = (b == 0) ? id : (id ^ 16'h5555);
      s_rdata  = beat_data(id, b);
      s_rresp  = 2'(b);
      s_rlast  = (b == nbeats - 1);
      s_rvalid = 1'b1;
      if (hit) begin
         e.port = port;
         e.rid  = s_rid;
         e.data = s_rdata;
         e.resp = s_rresp;
         e.last = s_rlast;
         sb.push_back(e);
      end
   endtask

   // One full burst from the IDLE lookup through RELEASE (or the drained tail of a miss).
   task automatic run_burst(input logic [15:0] id, input int nbeats, input bit hit,
                            input int port, input int stall_at, input int stall_len,
                            input bit chain, input logic [15:0] next_id, input int next_nbeats);
      logic [1:0] exp_valid;
      bit         done;
      bit         exp_ready;
      int         stall;
      exp_valid = hit ? 2'(1 << port) : 2'b00;
      drive_beat(id, 0, nbeats, hit, port);
      @(negedge clock);
      check_output("idle_lookup", tbl_lookup, 1'b1);
      check_output("idle_tbl_id", tbl_id, id);
      check_output("idle_s_rready", s_rready, 1'b0);
      check_output("idle_m_rvalid", m_rvalid, 2'b00);
      tick();
      @(negedge clock);
      check_output("wait_miss", miss, !hit);
      check_output("wait_tbl_id", tbl_id, id);
      check_output("wait_lookup", tbl_lookup, 1'b0);
      check_output("wait_s_rready", s_rready, 1'b0);
      check_output("wait_m_rvalid", m_rvalid, 2'b00);
      tick();
      for (int b = 0; b < nbeats; b++) begin
         if (b > 0) drive_beat(id, b, nbeats, hit, port);
         stall = 0;
         if (hit && b == stall_at && stall_len > 0) m_rready[port] = 1'b0;
         done = 1'b0;
         for (int c = 0; c < 20 && !done; c++) begin
            @(negedge clock);
            exp_ready = !hit || !(b == stall_at && stall < stall_len);
            check_output("beat_m_rvalid", m_rvalid, exp_valid);
            check_output("beat_s_rready", s_rready, exp_ready);
            check_output("beat_tbl_id", tbl_id, id);
            check_output("beat_invalidate", tbl_invalidate, 1'b0);
            tick();
            if (exp_ready) begin
               done = 1'b1;
            end else begin
               stall++;
               if (stall == stall_len) m_rready[port] = 1'b1;
            end
         end
         check_output("beat_no_timeout", done, 1'b1);
      end
      s_rvalid = 1'b0;
      if (hit) begin
         if (chain) begin
            s_rid    = next_id;
            s_rdata  = beat_data(next_id, 0);
            s_rresp  = 2'b00;
            s_rlast  = (next_nbeats == 1);
            s_rvalid = 1'b1;
         end
         @(negedge clock);
         check_output("release_invalidate", tbl_invalidate, 1'b1);
         check_output("release_tbl_id", tbl_id, id);
         check_output("release_lookup", tbl_lookup, 1'b0);
         check_output("release_s_rready", s_rready, 1'b0);
         check_output("release_m_rvalid", m_rvalid, 2'b00);
         tick();
      end else begin
         @(negedge clock);
         check_output("drop_end_invalidate", tbl_invalidate, 1'b0);
         check_output("drop_end_s_rready", s_rready, 1'b0);
         tick();
      end
   endtask

   // Port-side monitor: every accepted beat must match the head of the scoreboard.
   always @(negedge clock) begin
      if (reset) begin
         check_output("m_rvalid_onehot", ($countones(m_rvalid) <= 1), 1'b1);
         check_output("lookup_invalidate_exclusive", (tbl_lookup && tbl_invalidate), 1'b0);
         if (tbl_invalidate) inv_count++;
         if (miss) miss_pulses++;
         for (int p = 0; p < 2; p++) begin
            if (m_rvalid[p] && m_rready[p]) begin
               check_output("sb_has_entry", (sb.size() > 0), 1'b1);
               if (sb.size() > 0) begin
                  mon_beat = sb.pop_front();
                  check_output("sb_port", p, mon_beat.port);
                  check_output("sb_rid", m_rid, mon_beat.rid);
                  check_output("sb_rdata", m_rdata, mon_beat.data);
                  check_output("sb_rresp", m_rresp, mon_beat.resp);
                  check_output("sb_rlast", m_rlast, mon_beat.last);
               end
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog expired");
      $fatal(1, "[TB] simulation did not terminate");
   end

   initial begin
      checks      = 0;
      errors      = 0;
      inv_count   = 0;
      miss_pulses = 0;
      reset       = 1'b0;
      s_rid       = '0;
      s_rdata     = '0;
      s_rresp     = '0;
      s_rlast     = 1'b0;
      s_rvalid    = 1'b0;
      m_rready    = 2'b00;
      repeat (3) tick();
      @(negedge clock);
      check_output("reset_s_rready", s_rready, 1'b0);
      check_output("reset_m_rvalid", m_rvalid, 2'b00);
      check_output("reset_lookup", tbl_lookup, 1'b0);
      check_output("reset_invalidate", tbl_invalidate, 1'b0);
      check_output("reset_miss", miss, 1'b0);
      check_output("reset_miss_count", miss_count, 16'h0000);
      tick();
      reset = 1'b1;
      tick();

      $display("[TB] single-beat hit to port 1");
      m_rready = 2'b10;
      run_burst(16'h01ad, 1, 1'b1, 1, -1, 0, 1'b0, 16'h0, 0);
      @(negedge clock);
      check_output("t1_idle_s_rready", s_rready, 1'b0);
      check_output("t1_idle_lookup", tbl_lookup, 1'b0);
      check_output("t1_inv_count", inv_count, 1);
      tick();

      $display("[TB] 4-beat burst to port 0 with back-pressure");
      m_rready = 2'b01;
      run_burst(16'h018d, 4, 1'b1, 0, 1, 3, 1'b0, 16'h0, 0);
      check_output("t2_inv_count", inv_count, 2);
      check_output("t2_sb_drained", sb.size(), 0);

      $display("[TB] 3-beat miss");
      m_rready = 2'b11;
      run_burst(16'h090d, 3, 1'b0, 0, -1, 0, 1'b0, 16'h0, 0);
      check_output("t3_miss_count", miss_count, 16'd1);
      check_output("t3_miss_pulses", miss_pulses, 1);
      check_output("t3_inv_count", inv_count, 2);

      $display("[TB] back-to-back bursts");
      m_rready = 2'b11;
      run_burst(16'h01ad, 2, 1'b1, 1, -1, 0, 1'b1, 16'h01ed, 2);
      run_burst(16'h01ed, 2, 1'b1, 0, -1, 0, 1'b0, 16'h0, 0);
      check_output("t4_inv_count", inv_count, 4);
      check_output("t4_sb_drained", sb.size(), 0);

      $display("[TB] reset during beat 2 of 4");
      m_rready = 2'b01;
      drive_beat(16'h018d, 0, 4, 1'b1, 0);
      tick();
      tick();
      tick();
      drive_beat(16'h018d, 1, 4, 1'b1, 0);
      #1;
      check_output("t5_pre_reset_m_rvalid", m_rvalid, 2'b01);
      reset    = 1'b0;
      s_rvalid = 1'b0;
      #1;
      check_output("t5_rst_s_rready", s_rready, 1'b0);
      check_output("t5_rst_m_rvalid", m_rvalid, 2'b00);
      check_output("t5_rst_lookup", tbl_lookup, 1'b0);
      check_output("t5_rst_invalidate", tbl_invalidate, 1'b0);
      check_output("t5_rst_miss", miss, 1'b0);
      check_output("t5_rst_miss_count", miss_count, 16'h0000);
      sb.delete();
      tick();
      tick();
      reset = 1'b1;
      tick();
      run_burst(16'h01ed, 1, 1'b1, 0, -1, 0, 1'b0, 16'h0, 0);
      check_output("t5_inv_count", inv_count, 5);

      $display("[TB] miss counter saturation");
      force dut.miss_count = 16'hFFFE;
      #1;
      release dut.miss_count;
      @(negedge clock);
      check_output("t6_preload", miss_count, 16'hFFFE);
      tick();
      run_burst(16'h0bad, 1, 1'b0, 0, -1, 0, 1'b0, 16'h0, 0);
      check_output("t6_reach_max", miss_count, 16'hFFFF);
      run_burst(16'h0bee, 2, 1'b0, 0, -1, 0, 1'b0, 16'h0, 0);
      check_output("t6_hold_max", miss_count, 16'hFFFF);
      check_output("t6_miss_pulses", miss_pulses, 3);
      check_output("final_sb_empty", sb.size(), 0);
      check_output("final_inv_count", inv_count, 5);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
